// File: rtl/branch_unit.sv
// Registered branch resolution stage: condition evaluation, target/redirect computation,
// misprediction flag and an optional 2-bit BHT (enabled by defining BRANCH_UNIT_BHT_EN).
module branch_unit #(
    parameter int WORD_SIZE = 32,
    parameter int BHT_DEPTH = 64,
    parameter int INDEX_LSB = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_pc,
    input  logic [WORD_SIZE-1:0] in_r1,
    input  logic [WORD_SIZE-1:0] in_r2,
    input  logic [WORD_SIZE-1:0] in_imm,
    input  logic [2:0]           in_funct3,
    input  logic                 in_pred_taken,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_taken,
    output logic [WORD_SIZE-1:0] out_target,
    output logic [WORD_SIZE-1:0] out_redirect_pc,
    output logic                 out_mispredict,
    output logic                 out_illegal,
    input  logic [WORD_SIZE-1:0] lookup_pc,
    output logic                 lookup_taken
);

    localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

    logic                 eq_s;
    logic                 lt_s;
    logic                 ltu_s;
    logic                 taken_s;
    logic                 illegal_s;
    logic                 accept_s;
    logic [WORD_SIZE-1:0] target_s;
    logic [WORD_SIZE-1:0] fallthru_s;
    logic                 unused_s;

    logic                 out_valid_q,      out_valid_d;
    logic                 out_taken_q,      out_taken_d;
    logic [WORD_SIZE-1:0] out_target_q,     out_target_d;
    logic [WORD_SIZE-1:0] out_redirect_q,   out_redirect_d;
    logic                 out_mispredict_q, out_mispredict_d;
    logic                 out_illegal_q,    out_illegal_d;

    assign eq_s       = (in_r1 == in_r2);
    assign lt_s       = ($signed(in_r1) < $signed(in_r2));
    assign ltu_s      = (in_r1 < in_r2);
    assign target_s   = in_pc + in_imm;
    assign fallthru_s = in_pc + WORD_SIZE'(32'd4);

    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept_s = in_valid && in_ready;

    // Decode funct3 into a resolved direction; the two reserved codes are illegal and never taken.
    always_comb begin
        taken_s   = 1'b0;
        illegal_s = 1'b0;
        case (in_funct3)
            3'b000:  taken_s = eq_s;
            3'b001:  taken_s = !eq_s;
            3'b100:  taken_s = lt_s;
            3'b101:  taken_s = !lt_s;
            3'b110:  taken_s = ltu_s;
            3'b111:  taken_s = !ltu_s;
            default: begin
                taken_s   = 1'b0;
                illegal_s = 1'b1;
            end
        endcase
    end

    // Output register next state: load on accept, otherwise hold; valid follows flush/accept/drain.
    always_comb begin
        out_valid_d      = out_valid_q;
        out_taken_d      = out_taken_q;
        out_target_d     = out_target_q;
        out_redirect_d   = out_redirect_q;
        out_mispredict_d = out_mispredict_q;
        out_illegal_d    = out_illegal_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (accept_s) begin
            out_taken_d      = taken_s;
            out_target_d     = target_s;
            out_redirect_d   = taken_s ? target_s : fallthru_s;
            out_mispredict_d = !illegal_s && (taken_s != in_pred_taken);
            out_illegal_d    = illegal_s;
        end else begin
            out_taken_d      = out_taken_q;
            out_target_d     = out_target_q;
            out_redirect_d   = out_redirect_q;
            out_mispredict_d = out_mispredict_q;
            out_illegal_d    = out_illegal_q;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q      <= 1'b0;
            out_taken_q      <= 1'b0;
            out_target_q     <= '0;
            out_redirect_q   <= '0;
            out_mispredict_q <= 1'b0;
            out_illegal_q    <= 1'b0;
        end else begin
            out_valid_q      <= out_valid_d;
            out_taken_q      <= out_taken_d;
            out_target_q     <= out_target_d;
            out_redirect_q   <= out_redirect_d;
            out_mispredict_q <= out_mispredict_d;
            out_illegal_q    <= out_illegal_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_taken       = out_taken_q;
    assign out_target      = out_target_q;
    assign out_redirect_pc = out_redirect_q;
    assign out_mispredict  = out_mispredict_q;
    assign out_illegal     = out_illegal_q;

`ifdef BRANCH_UNIT_BHT_EN
    // Saturating 2-bit counter step: up when taken, down otherwise.
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        logic [1:0] res;
        if (up) begin
            res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return res;
    endfunction

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic             bht_we_s;
    logic [1:0]       cnt_nxt_s;

    assign wr_idx_s  = in_pc[INDEX_LSB +: IDX_W];
    assign rd_idx_s  = lookup_pc[INDEX_LSB +: IDX_W];
    assign bht_we_s  = accept_s && !illegal_s;
    assign cnt_nxt_s = sat_step(bht_q[wr_idx_s], taken_s);

    // Counter table; flush never touches it, only reset returns entries to weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (bht_we_s) begin
            bht_q[wr_idx_s] <= cnt_nxt_s;
        end
    end

    assign lookup_taken = bht_q[rd_idx_s][1];
    assign unused_s     = ^lookup_pc;
`else
    assign lookup_taken = 1'b0;
    assign unused_s     = ^{lookup_pc, lookup_pc[INDEX_LSB +: IDX_W]};
`endif

endmodule
